// File: rtl/go_request_conditioner_if.sv
// ============================================================================
// Module : go_request_conditioner_if
// Brief  : Request inputs and go/status outputs of the go-request conditioner
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface go_request_conditioner_if #(
    parameter int CNT_W = 8
);
    logic             sensor_raw;
    logic             emerg_raw;
    logic             fsm_busy;
    logic [1:0]       go_control;
    logic             sensor_pending;
    logic             emerg_pending;
    logic [CNT_W-1:0] req_count;

    modport master (
        output sensor_raw, emerg_raw, fsm_busy,
        input  go_control, sensor_pending, emerg_pending, req_count
    );

    modport slave (
        input  sensor_raw, emerg_raw, fsm_busy,
        output go_control, sensor_pending, emerg_pending, req_count
    );
endinterface

`default_nettype wire

// File: rtl/go_request_conditioner.sv
// ============================================================================
// Module : go_request_conditioner
// Brief  : Synchronises, debounces and latches sensor/emergency requests and
//          drives the 2-bit goControl bus of the intersection light FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module go_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DB_W            = 20,
    parameter int MIN_WAIT_CYCLES = 150000000,
    parameter int WAIT_W          = 28,
    parameter int CNT_W           = 8
) (
    input  wire logic               clk,
    input  wire logic               resetn,
    go_request_conditioner_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ASSERT = 2'd2
    } state_t;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MIN_WAIT_CYCLES - 1);

    // Channel index 0 is the car sensor, 1 is the emergency request.
    logic [1:0]        sync1_q, sync1_d;
    logic [1:0]        sync2_q, sync2_d;
    logic [1:0]        deb_q,   deb_d;
    logic [1:0]        pend_q,  pend_d;
    logic [DB_W-1:0]   cnt_q [2];
    logic [DB_W-1:0]   cnt_d [2];
    logic              busy_q,  busy_d;
    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wcnt_q,  wcnt_d;
    logic [CNT_W-1:0]  req_q,   req_d;
    logic [1:0]        accept;
    logic              served;
    logic [CNT_W:0]    req_sum;

    always_comb begin
        sync1_d = {bus.emerg_raw, bus.sensor_raw};
        sync2_d = sync1_q;

        for (int i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_W'(1);
                end
            end
        end

        accept = deb_d & ~deb_q;
        busy_d = bus.fsm_busy;
        served = bus.fsm_busy & ~busy_q;

        // A fresh accept outranks a serve landing on the same edge.
        pend_d = accept | (pend_q & {2{~served}});

        state_d = state_q;
        wcnt_d  = wcnt_q;
        if (accept[0] && (state_q == S_IDLE || served)) begin
            state_d = S_WAIT;
            wcnt_d  = '0;
        end else if (served) begin
            state_d = S_IDLE;
        end else if (state_q == S_WAIT) begin
            if (wcnt_q == WAIT_LAST) begin
                state_d = S_ASSERT;
            end else begin
                wcnt_d = wcnt_q + WAIT_W'(1);
            end
        end

        req_sum = {1'b0, req_q} + {{CNT_W{1'b0}}, accept[0]} + {{CNT_W{1'b0}}, accept[1]};
        req_d   = req_sum[CNT_W] ? {CNT_W{1'b1}} : req_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            pend_q  <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            req_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            pend_q  <= pend_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            busy_q  <= busy_d;
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            req_q   <= req_d;
        end
    end

    assign bus.go_control     = {pend_q[1], state_q == S_ASSERT};
    assign bus.sensor_pending = pend_q[0];
    assign bus.emerg_pending  = pend_q[1];
    assign bus.req_count      = req_q;

endmodule

`default_nettype wire

// File: tb/tb_go_request_conditioner.sv
// ============================================================================
// Module : tb_go_request_conditioner
// Brief  : Directed self-checking bench for go_request_conditioner
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_go_request_conditioner;

    localparam int DEB   = 4;
    localparam int MINW  = 3;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic resetn;
    logic check_en;
    int   n_assert;
    int   n_fail;

    go_request_conditioner_if #(.CNT_W(CNT_W)) bus ();

    go_request_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .DB_W            (3),
        .MIN_WAIT_CYCLES (MINW),
        .WAIT_W          (4),
        .CNT_W           (CNT_W)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: requests as run lengths of stable input and elapsed wait time.
    logic [1:0] m_ff1, m_s, m_deb, m_pend;
    int         m_run [2];
    logic       m_busy, m_active;
    int         m_elapsed, m_cnt;

    always @(posedge clk) begin : model
        logic [1:0] acc;
        logic       served;
        if (!resetn) begin
            m_ff1 = '0; m_s = '0; m_deb = '0; m_pend = '0;
            m_run[0] = 0; m_run[1] = 0;
            m_busy = 1'b0; m_active = 1'b0; m_elapsed = 0; m_cnt = 0;
        end else begin
            acc = 2'b00;
            for (int ch = 0; ch < 2; ch++) begin
                if (m_s[ch] != m_deb[ch]) m_run[ch] = m_run[ch] + 1;
                else                      m_run[ch] = 0;
                if (m_run[ch] == DEB) begin
                    m_deb[ch] = m_s[ch];
                    m_run[ch] = 0;
                    acc[ch]   = m_s[ch];
                end
            end
            m_s    = m_ff1;
            m_ff1  = {bus.emerg_raw, bus.sensor_raw};
            served = bus.fsm_busy && !m_busy;
            m_busy = bus.fsm_busy;
            for (int ch = 0; ch < 2; ch++) begin
                if (acc[ch])     m_pend[ch] = 1'b1;
                else if (served) m_pend[ch] = 1'b0;
            end
            if (acc[0] && (!m_active || served)) begin
                m_active  = 1'b1;
                m_elapsed = 0;
            end else if (served) begin
                m_active = 1'b0;
            end else if (m_active && m_elapsed < MINW) begin
                m_elapsed++;
            end
            m_cnt = m_cnt + int'(acc[0]) + int'(acc[1]);
            if (m_cnt > CMAX) m_cnt = CMAX;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_go_control", int'(bus.go_control),
                int'({m_pend[1], (m_active && m_elapsed >= MINW)}));
            chk("model_sensor_pending", int'(bus.sensor_pending), int'(m_pend[0]));
            chk("model_emerg_pending",  int'(bus.emerg_pending),  int'(m_pend[1]));
            chk("model_req_count",      int'(bus.req_count),      m_cnt);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        check_en = 1'b0;
        resetn   = 1'b0;
        bus.sensor_raw = 1'b0;
        bus.emerg_raw  = 1'b0;
        bus.fsm_busy   = 1'b0;

        tick(1);
        check_en = 1'b1;
        tick(2);
        chk("reset_go_control", int'(bus.go_control), 0);
        chk("reset_sensor_pending", int'(bus.sensor_pending), 0);
        chk("reset_emerg_pending", int'(bus.emerg_pending), 0);
        chk("reset_req_count", int'(bus.req_count), 0);
        resetn = 1'b1;
        tick(2);

        // Short glitch is filtered out
        bus.sensor_raw = 1'b1;
        tick(3);
        bus.sensor_raw = 1'b0;
        tick(10);
        chk("glitch_no_pending", int'(bus.sensor_pending), 0);
        chk("glitch_no_count", int'(bus.req_count), 0);

        // Held sensor: pending after edge 6, go after edge 9
        bus.sensor_raw = 1'b1;
        tick(5);
        chk("sensor_pending_edge5", int'(bus.sensor_pending), 0);
        tick(1);
        chk("sensor_pending_edge6", int'(bus.sensor_pending), 1);
        tick(2);
        chk("sensor_go_edge8", int'(bus.go_control), 0);
        tick(1);
        chk("sensor_go_edge9", int'(bus.go_control), 1);
        chk("sensor_count", int'(bus.req_count), 1);

        // Busy rise serves the request; held sensor is not re-accepted
        bus.fsm_busy = 1'b1;
        tick(1);
        chk("served_pending", int'(bus.sensor_pending), 0);
        chk("served_go", int'(bus.go_control), 0);
        tick(12);
        chk("held_no_rerequest", int'(bus.sensor_pending), 0);
        chk("held_count", int'(bus.req_count), 1);
        bus.fsm_busy   = 1'b0;
        bus.sensor_raw = 1'b0;
        tick(10);

        // Emergency overrides a waiting sensor; both accept on one edge
        bus.sensor_raw = 1'b1;
        bus.emerg_raw  = 1'b1;
        tick(6);
        chk("emerg_go", int'(bus.go_control), 2);
        chk("dual_accept_count", int'(bus.req_count), 3);
        bus.fsm_busy = 1'b1;
        tick(1);
        chk("emerg_served_go", int'(bus.go_control), 0);
        chk("emerg_served_pending", int'(bus.emerg_pending), 0);
        chk("emerg_served_sensor", int'(bus.sensor_pending), 0);
        bus.fsm_busy   = 1'b0;
        bus.sensor_raw = 1'b0;
        bus.emerg_raw  = 1'b0;
        tick(10);

        // Accept coincides with busy rise: accept wins, wait restarts
        bus.sensor_raw = 1'b1;
        tick(5);
        bus.fsm_busy = 1'b1;
        tick(1);
        chk("accept_beats_serve", int'(bus.sensor_pending), 1);
        tick(2);
        chk("restart_go_edge8", int'(bus.go_control), 0);
        tick(1);
        chk("restart_go_edge9", int'(bus.go_control), 1);
        chk("restart_count", int'(bus.req_count), 4);
        bus.fsm_busy   = 1'b0;
        bus.sensor_raw = 1'b0;
        tick(10);

        // Saturation: 260 further accepts
        for (int k = 0; k < 130; k++) begin
            bus.sensor_raw = 1'b1;
            bus.emerg_raw  = 1'b1;
            tick(7);
            bus.sensor_raw = 1'b0;
            bus.emerg_raw  = 1'b0;
            tick(7);
        end
        chk("count_saturated", int'(bus.req_count), 255);
        bus.sensor_raw = 1'b1;
        bus.emerg_raw  = 1'b1;
        tick(8);
        chk("both_go", int'(bus.go_control), 3);
        chk("count_still_saturated", int'(bus.req_count), 255);

        // Reset mid-operation with inputs held high
        resetn = 1'b0;
        tick(1);
        chk("midreset_go", int'(bus.go_control), 0);
        chk("midreset_sensor_pending", int'(bus.sensor_pending), 0);
        chk("midreset_emerg_pending", int'(bus.emerg_pending), 0);
        chk("midreset_count", int'(bus.req_count), 0);
        resetn = 1'b1;
        tick(5);
        chk("reaccept_edge5", int'(bus.sensor_pending), 0);
        tick(1);
        chk("reaccept_sensor_edge6", int'(bus.sensor_pending), 1);
        chk("reaccept_emerg_edge6", int'(bus.emerg_pending), 1);
        chk("reaccept_count", int'(bus.req_count), 2);
        tick(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
